// File: rtl/result_argmax_buffer.sv
// Result FIFO with a sequential argmax engine that resolves one class per cycle for the head entry.
// Optional `RESULT_DROP_CNT_EN adds a saturating drop_cnt output counting writes refused while full.
module result_argmax_buffer #(
  parameter int NUM_CLASS = 5,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 4,
  localparam int IDX_W    = (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1,
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_valid,
  input  logic [NUM_CLASS*DATA_W-1:0] wr_data,
  output logic                        wr_ready,
  input  logic                        rd_req,
  output logic                        rd_valid,
  output logic [IDX_W-1:0]            rd_index,
  output logic [DATA_W-1:0]           rd_max,
  output logic [CNT_W-1:0]            count,
  output logic                        busy
`ifdef RESULT_DROP_CNT_EN
  ,
  output logic [15:0]                 drop_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int VEC_W = NUM_CLASS * DATA_W;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  logic [VEC_W-1:0]         mem_q [DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         count_q, count_d;
  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         scan_ptr_q, scan_ptr_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic signed [DATA_W-1:0] max_q, max_d;
  logic                     push, pop;
  logic [VEC_W-1:0]         head;
  logic signed [DATA_W-1:0] cand;

  function automatic logic signed [DATA_W-1:0] score_at(input logic [VEC_W-1:0] vec,
                                                        input logic [IDX_W-1:0] k);
    return $signed(vec[int'(k)*DATA_W +: DATA_W]);
  endfunction

  assign wr_ready = (count_q != CNT_W'(DEPTH));
  assign push     = wr_valid && wr_ready;
  assign pop      = (state_q == DONE) && rd_req;
  assign head     = mem_q[rd_ptr_q];
  assign cand     = score_at(head, scan_ptr_q);

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q;
    state_d    = state_q;
    scan_ptr_d = scan_ptr_q;
    idx_d      = idx_q;
    max_d      = max_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          max_d = score_at(head, '0);
          idx_d = '0;
          if (NUM_CLASS == 1) begin
            state_d = DONE;
          end else begin
            scan_ptr_d = IDX_W'(1);
            state_d    = SCAN;
          end
        end
      end
      SCAN: begin
        // strict compare keeps the lowest index on ties
        if (cand > max_q) begin
          max_d = cand;
          idx_d = scan_ptr_q;
        end
        if (scan_ptr_q == IDX_W'(NUM_CLASS - 1)) begin
          state_d = DONE;
        end else begin
          scan_ptr_d = scan_ptr_q + 1'b1;
        end
      end
      DONE: begin
        if (rd_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Payload storage carries no reset; only occupied slots are ever read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= IDLE;
      scan_ptr_q <= '0;
      idx_q      <= '0;
      max_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      scan_ptr_q <= scan_ptr_d;
      idx_q      <= idx_d;
      max_q      <= max_d;
    end
  end

  assign rd_valid = (state_q == DONE);
  assign rd_index = rd_valid ? idx_q : '0;
  assign rd_max   = rd_valid ? max_q : '0;
  assign count    = count_q;
  assign busy     = (state_q == SCAN);

`ifdef RESULT_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (wr_valid && !wr_ready && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_result_argmax_buffer.sv
// Bench for result_argmax_buffer: queue-based reference with latency bookkeeping plus a NUM_CLASS=1 instance.
module tb_result_argmax_buffer;

  localparam int NC    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int VW    = NC * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid;
  logic [VW-1:0] wr_data;
  logic          wr_ready;
  logic          rd_req;
  logic          rd_valid;
  logic [2:0]    rd_index;
  logic [DW-1:0] rd_max;
  logic [2:0]    count;
  logic          busy;
`ifdef RESULT_DROP_CNT_EN
  logic [15:0]   drop_cnt;
  logic [15:0]   d1_drop;
`endif

  logic          w1_valid;
  logic [7:0]    w1_data;
  logic          w1_ready;
  logic          r1_req;
  logic          r1_valid;
  logic [0:0]    r1_index;
  logic [7:0]    r1_max;
  logic [1:0]    c1_count;
  logic          b1_busy;

  always #5 clk = ~clk;

  result_argmax_buffer #(.NUM_CLASS(NC), .DATA_W(DW), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_req(rd_req), .rd_valid(rd_valid), .rd_index(rd_index), .rd_max(rd_max),
    .count(count), .busy(busy)
`ifdef RESULT_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  result_argmax_buffer #(.NUM_CLASS(1), .DATA_W(8), .DEPTH(2)) u_dut1 (
    .clk(clk), .rst(rst), .wr_valid(w1_valid), .wr_data(w1_data), .wr_ready(w1_ready),
    .rd_req(r1_req), .rd_valid(r1_valid), .rd_index(r1_index), .rd_max(r1_max),
    .count(c1_count), .busy(b1_busy)
`ifdef RESULT_DROP_CNT_EN
    , .drop_cnt(d1_drop)
`endif
  );

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [VW-1:0] q[$];
  int            rem     = -1;  // edges until the head result is due; -1 means no head
  int            drops   = 0;
  int            n_pops  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] mk5(input int a, input int b, input int c, input int d, input int e);
    logic [VW-1:0] v;
    v[0*DW +: DW] = a;
    v[1*DW +: DW] = b;
    v[2*DW +: DW] = c;
    v[3*DW +: DW] = d;
    v[4*DW +: DW] = e;
    return v;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    int s;
    for (int k = 0; k < NC; k++) begin
      if ($urandom_range(0, 1) == 1) s = int'($urandom_range(0, 6)) - 3;
      else s = int'($urandom);
      v[k*DW +: DW] = s;
    end
    return v;
  endfunction

  // Find the maximum value first, then the first class holding it.
  function automatic void ref_argmax(input logic [VW-1:0] v, output int idx, output logic [DW-1:0] mx);
    int best;
    bit found;
    best = int'(v[0 +: DW]);
    for (int k = 1; k < NC; k++)
      if (int'(v[k*DW +: DW]) > best) best = int'(v[k*DW +: DW]);
    found = 0;
    idx = 0;
    for (int k = 0; k < NC; k++)
      if (!found && int'(v[k*DW +: DW]) == best) begin
        idx = k;
        found = 1;
      end
    mx = best;
  endfunction

  task automatic cycle(input logic wv, input logic [VW-1:0] wd, input logic rr);
    int ridx;
    logic [DW-1:0] rmx;
    bit full, popped, pushed;
    check("count", count, q.size());
    check("wr_ready", wr_ready, q.size() != DEPTH);
    check("rd_valid", rd_valid, rem == 0);
    check("busy", busy, (rem >= 1) && (rem < NC));
`ifdef RESULT_DROP_CNT_EN
    check("drop_cnt", drop_cnt, (drops > 65535) ? 65535 : drops);
`endif
    if (rem == 0) begin
      ref_argmax(q[0], ridx, rmx);
      check("rd_index", rd_index, ridx);
      check("rd_max", rd_max, rmx);
    end else begin
      check("rd_index_gated", rd_index, 0);
      check("rd_max_gated", rd_max, 0);
    end
    popped = (rem == 0) && rr;
    full   = (q.size() == DEPTH);
    pushed = wv && !full;
    if (wv && full) drops++;
    wr_valid = wv;
    wr_data  = wd;
    rd_req   = rr;
    @(negedge clk);
    if (popped) begin
      void'(q.pop_front());
      n_pops++;
    end
    if (pushed) q.push_back(wd);
    if (popped) rem = (q.size() > 0) ? NC : -1;
    else if (rem > 0) rem--;
    else if (rem < 0 && pushed) rem = NC;
    wr_valid = 1'b0;
    rd_req   = 1'b0;
  endtask

  task automatic drain();
    for (int g = 0; g < 200 && q.size() > 0; g++) cycle(1'b0, '0, 1'b1);
    check("drain_empty", count, 0);
  endtask

  initial begin
    int p0;
    rst = 1'b1; wr_valid = 1'b0; wr_data = '0; rd_req = 1'b0;
    w1_valid = 1'b0; w1_data = '0; r1_req = 1'b0;
    #2;
    check("rst_wr_ready", wr_ready, 1);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_index", rd_index, 0);
    check("rst_rd_max", rd_max, 0);
    check("rst_count", count, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;

    // single vector, max in class 3
    cycle(1'b1, mk5(10, -3, 7, 25, 4), 1'b0);
    for (int i = 0; i < NC; i++) cycle(1'b0, '0, 1'b0);
    check("t1_index", rd_index, 3);
    check("t1_max", rd_max, 32'd25);
    cycle(1'b0, '0, 1'b1);
    check("t1_pop_valid", rd_valid, 0);
    check("t1_pop_count", count, 0);
    check("t1_pop_max", rd_max, 0);

    // ties and negatives
    cycle(1'b1, mk5(-5, -2, -2, -9, -2), 1'b0);
    for (int i = 0; i < NC; i++) cycle(1'b0, '0, 1'b0);
    check("t2_index", rd_index, 1);
    check("t2_max", rd_max, 32'hFFFF_FFFE);
    cycle(1'b0, '0, 1'b1);

    // fill, overflow, drain in order
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, rand_vec(), 1'b0);
    check("t3_full_count", count, 4);
    check("t3_full_ready", wr_ready, 0);
    cycle(1'b1, rand_vec(), 1'b0);
    check("t3_count_after_drop", count, 4);
`ifdef RESULT_DROP_CNT_EN
    check("t3_drop_cnt", drop_cnt, 1);
`endif
    drain();

    // rd_req held high while streaming three vectors
    p0 = n_pops;
    for (int i = 0; i < 40; i++) cycle((i == 0) || (i == 2) || (i == NC + 1), rand_vec(), 1'b1);
    check("t4_pops", n_pops - p0, 3);
    check("t4_empty", count, 0);

    // async reset while the second of three entries is scanning
    for (int i = 0; i < 3; i++) cycle(1'b1, rand_vec(), 1'b0);
    for (int g = 0; g < 50 && rem != 0; g++) cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);
    check("t5_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_valid", rd_valid, 0);
    check("t5_rst_count", count, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_index", rd_index, 0);
    check("t5_rst_max", rd_max, 0);
    check("t5_rst_ready", wr_ready, 1);
    q.delete();
    rem = -1;
    drops = 0;
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, rand_vec(), 1'b0);
    drain();

    // randomized traffic
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 1) == 1, rand_vec(), $urandom_range(0, 3) != 0);
    drain();

    // NUM_CLASS=1, DEPTH=2, DATA_W=8 instance
    w1_valid = 1'b1; w1_data = 8'h80;
    @(negedge clk);
    w1_valid = 1'b0;
    check("p1_valid_early", r1_valid, 0);
    check("p1_count", c1_count, 1);
    @(negedge clk);
    check("p1_valid", r1_valid, 1);
    check("p1_index", r1_index, 0);
    check("p1_max", r1_max, 8'h80);
    check("p1_busy", b1_busy, 0);
    w1_valid = 1'b1; w1_data = 8'h05;
    @(negedge clk);
    w1_valid = 1'b0;
    check("p1_full_ready", w1_ready, 0);
    r1_req = 1'b1;
    @(negedge clk);
    r1_req = 1'b0;
    check("p1_pop_count", c1_count, 1);
    check("p1_pop_valid", r1_valid, 0);
    @(negedge clk);
    check("p1_second_max", r1_max, 8'h05);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/result_argmax_buffer.md
Name: result_argmax_buffer

Overview:
- Multi-entry result store for the classifier output stage. Successor to the single-register result memory with its combinational compare.
- Buffers up to DEPTH result vectors of NUM_CLASS signed scores in a FIFO.
- Resolves each head vector with a sequential argmax engine that compares one class per cycle.
- Presents {index, max score} to the bus side through a valid/pop handshake.

Parameters:
NUM_CLASS, 5, scores per result vector (>=1)
DATA_W, 32, width of one signed score
DEPTH, 4, FIFO entries (power of 2, >=2)
IDX_W, $clog2(NUM_CLASS) with minimum 1 (derived, localparam), width of the class index
CNT_W, $clog2(DEPTH+1) (derived, localparam), width of the occupancy count

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
wr_valid  in  1  write request for one result vector
wr_data  in  NUM_CLASS*DATA_W  packed vector; class k occupies bits [k*DATA_W +: DATA_W]
wr_ready  out  1  FIFO not full
rd_req  in  1  consume current argmax result (pop)
rd_valid  out  1  argmax result for head entry ready
rd_index  out  IDX_W  winning class index
rd_max  out  DATA_W  winning score
count  out  CNT_W  entries in FIFO, including the head under evaluation
busy  out  1  argmax engine in SCAN state

Behaviour:
- Reset: async clear.
  - FIFO pointers and count = 0.
  - FSM enters IDLE; max/index registers = 0.
  - Outputs: wr_ready=1, rd_valid=0, rd_index=0, rd_max=0, busy=0.
  - Reset mid-SCAN or mid-DONE discards all entries; no partial result survives.
- Write:
  - A vector is accepted on a clk edge when wr_valid && wr_ready.
  - wr_ready = (count != DEPTH). It is combinational from count only and independent of rd_req.
  - A write while full is ignored.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - If count>0: load max=class0 and index=0 of the head entry.
  - If NUM_CLASS==1, go to DONE; otherwise set scan ptr=1 and go to SCAN.
- SCAN, one class per cycle at scan ptr:
  - Signed compare. Replace only if the score is strictly greater, so on ties the lowest index wins.
  - If ptr==NUM_CLASS-1, go to DONE; otherwise ptr++.
- DONE:
  - rd_valid=1; rd_index/rd_max show the registered result.
  - On rd_req: pop head (rd ptr++, count--) and go to IDLE.
  - rd_req outside DONE is ignored.
- Output gating: rd_index and rd_max are driven 0 whenever rd_valid=0.
- Latency:
  - The first vector written into an empty, idle block at edge E0 produces rd_valid after edge E0+NUM_CLASS.
  - Back-to-back entries: after the pop edge, the next result is valid NUM_CLASS cycles later (one IDLE cycle plus NUM_CLASS-1 SCAN cycles).
- Simultaneous push and pop in the same edge:
  - count unchanged; both pointers advance.
  - Allowed only when not full before the edge (wr_ready rule).
- The head entry is never overwritten while it is under evaluation or in DONE; it is occupied until popped.
- Pointers wrap modulo DEPTH.
- count is exact at all times: 0..DEPTH.

Optional Feature:
RESULT_DROP_CNT_EN
- Defined:
  - Adds output port drop_cnt (16 bits), reset 0.
  - Increments on every edge with wr_valid=1 and wr_ready=0.
  - Saturates at 16'hFFFF.
  - Cleared only by rst.
- Undefined: port and counter are absent; dropped writes leave no trace.

Test Plan:
- Reset then single write, scores {10,-3,7,25,4} (class0..4) -> rd_valid rises 5 cycles after accept; rd_index=3, rd_max=25; after rd_req: rd_valid=0, count=0, rd_index=0, rd_max=0.
- Ties and negatives {-5,-2,-2,-9,-2} -> rd_index=1, rd_max=-2 (FFFFFFFE).
- Write 4 vectors with no reads -> count=4, wr_ready=0; 5th write ignored (with RESULT_DROP_CNT_EN: drop_cnt=1); pop all 4 -> results in write order, each valid 5 cycles after the previous pop.
- Hold rd_req=1 constantly while streaming 3 vectors -> each result consumed in its first DONE cycle; simultaneous push/pop keeps count steady; no result lost or duplicated.
- Assert rst during SCAN of the 2nd of 3 queued entries -> all outputs 0 immediately (async), count=0; a fresh write then yields a correct result.
- Parameter run NUM_CLASS=1, DEPTH=2, DATA_W=8: write 8'h80 -> rd_valid 1 cycle after accept, rd_index=0, rd_max=8'h80.
